otter_intc: RTL and testbench
=============================

Name: otter_intc

Overview:
Memory-mapped interrupt controller that sits between the SoC's external interrupt inputs and the MCU's interrupt line, and answers on the IO bus.
- Synchronises up to N_SRC sources and latches them as edge- or level-pending.
- Masks them with an enable register and drives one registered interrupt request to the MCU.
- Serialises service with a claim/complete handshake: one source in service at a time, lowest index wins.

Parameters:
N_SRC, 32, number of interrupt sources (1..32)
BASE_ADDR, 32'h0001_1000, word-aligned base of the 5-word register window
SYNC_STAGES, 2, flops in each source synchroniser (>=2)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous assert, active-low
i_src  in  N_SRC  raw interrupt sources, asynchronous
i_iobus_re  in  1  read strobe, one-cycle
i_iobus_we  in  1  write strobe, one-cycle
i_iobus_sel  in  4  byte lane enables
i_iobus_addr  in  32  byte address
i_iobus_wdata  in  32  write data
o_iobus_rdata  out  32  read data, valid with o_iobus_ack, else 0
o_iobus_ack  out  1  one-cycle acknowledge
o_irq  out  1  interrupt request to MCU, registered

Behaviour:
Reset:
- All registers, synchronisers, previous-sample flops, FSM (IDLE), o_irq, o_iobus_ack and o_iobus_rdata go to 0.

Register map (offset from BASE_ADDR):
- 0x00 PENDING: RO except for edge sources; W1C per bit, lane-gated by i_iobus_sel.
- 0x04 ENABLE: RW, lane-gated.
- 0x08 EDGE: RW, lane-gated. 1 = rising-edge source, 0 = level source.
- 0x0C CLAIM:
  - Read returns id+1 of the lowest-index bit of PENDING & ENABLE, or 0 if none.
  - A non-zero read enters CLAIMED and, for an edge source, clears that pending bit.
  - Write (any sel != 0) of wdata[5:0] = id+1 is COMPLETE.
- 0x10 INSERVICE: RO. Returns the in-service id+1, or 0 in IDLE.
- Bits at index >= N_SRC read 0 and ignore writes.

Source path:
- Each source passes through a SYNC_STAGES-stage synchroniser.
- Edge detect compares the synchroniser output against its registered previous sample.
- Edge source: pending set on 0->1 of the synced value; held until W1C or claim.
- Level source: pending mirrors the synced value; W1C has no effect.
- Same bit, same cycle, set and clear (W1C or claim): set wins.

Latency:
- Source rise at edge t: synced at t+SYNC_STAGES, PENDING at t+SYNC_STAGES+1.
- o_irq rises at t+SYNC_STAGES+2 if the source is enabled and the FSM is IDLE.

FSM:
- IDLE: next o_irq = |(PENDING & ENABLE). A CLAIM read returning non-zero goes to CLAIMED, stores the id, and drops o_irq next cycle.
- CLAIMED: o_irq held 0.
  - CLAIM read returns 0 and has no side effect.
  - COMPLETE with the matching id returns to IDLE.
  - COMPLETE with a mismatched id, or the value 0, is ignored.
- Level source still high after COMPLETE: re-raises o_irq on the cycle after the return to IDLE.
- Disabling the in-service source does not leave CLAIMED; only COMPLETE does.

Bus:
- A request to an address inside [BASE_ADDR, BASE_ADDR+0x14) gets o_iobus_ack exactly one cycle later.
- rdata is captured from register state at the request cycle.
- Writes take effect at the request-cycle edge.
- Addresses outside the window: no ack, no side effect, rdata 0.
- re and we together: treated as a write only, with no claim side effect.
- Unaligned addr[1:0] is ignored (word-addressed).

Reset asserted mid-operation:
- Everything, including the CLAIMED state and pending edges, clears asynchronously.
- No ack is produced for a request in flight.

Decomposition:
- Package otter_intc_pkg: register offset localparams (OFF_PENDING, OFF_ENABLE, OFF_EDGE, OFF_CLAIM, OFF_INSERVICE), ID_W = 6, the typedef enum {IDLE, CLAIMED} intc_state_t, and WINDOW_BYTES = 0x14.
- One sub-module otter_intc_prio_enc: combinational find-first-set over N_SRC bits, outputs valid and index.
- Synchronisers are inline generate loops.

Test Plan:
- Reset/ID: hold i_rst_n low with i_src = 32'hFFFF_FFFF -> all reads return 0 and o_irq = 0. After release, ENABLE = 0 keeps o_irq at 0.
- Edge claim/complete:
  - Setup: EDGE = 0x1, ENABLE = 0x1; pulse i_src[0] for 1 cycle.
  - Timing: PENDING = 0x1 and o_irq = 1 exactly SYNC_STAGES+2 edges after the pulse.
  - Claim: CLAIM read returns 1; next cycle o_irq = 0, PENDING = 0, INSERVICE = 1.
  - Complete: write CLAIM = 1 -> INSERVICE = 0.
- Priority/level:
  - Setup: EDGE = 0, ENABLE = 0x28; hold i_src[3] and i_src[5] high.
  - Claims: CLAIM returns 4. In CLAIMED a second CLAIM returns 0. Write 6 (mismatch) is ignored, INSERVICE stays 4.
  - Re-raise: write 4 -> o_irq re-asserts the next cycle. CLAIM returns 4 again because the level is still high.
- Simultaneous set/clear: W1C PENDING bit 2 in the same cycle a synced rising edge arrives on source 2 (edge mode) -> PENDING[2] stays 1.
- Bus corners:
  - Read BASE_ADDR+0x14 -> no ack.
  - re & we together on CLAIM -> treated as COMPLETE, no claim.
  - Write ENABLE with sel = 4'b0010, data 32'hFFFF_FFFF -> ENABLE = 0x0000_FF00.
- Async reset mid-claim: assert i_rst_n low while CLAIMED, between clock edges -> o_irq and INSERVICE read 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/otter_intc_pkg.sv
// otter_intc shared definitions: register offsets, id width,
// controller state encoding and the size of the register window.
package otter_intc_pkg;

    localparam logic [4:0] OFF_PENDING   = 5'h00;
    localparam logic [4:0] OFF_ENABLE    = 5'h04;
    localparam logic [4:0] OFF_EDGE      = 5'h08;
    localparam logic [4:0] OFF_CLAIM     = 5'h0C;
    localparam logic [4:0] OFF_INSERVICE = 5'h10;

    localparam int ID_W = 6;

    localparam logic [31:0] WINDOW_BYTES = 32'h14;

    typedef enum logic {
        IDLE    = 1'b0,
        CLAIMED = 1'b1
    } intc_state_t;

endpackage

// File: rtl/otter_intc_prio_enc.sv
// Find-first-set over N bits; lowest set index wins.
// Ports: i_vec request vector, o_valid any bit set, o_idx lowest index.
import otter_intc_pkg::*;

module otter_intc_prio_enc #(
    parameter int N = 32
) (
    input  logic [N-1:0]    i_vec,
    output logic            o_valid,
    output logic [ID_W-1:0] o_idx
);

    always_comb begin
        o_valid = |i_vec;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = ID_W'(i);
        end
    end

endmodule

// File: rtl/otter_intc.sv
// Memory-mapped interrupt controller with claim/complete serialisation.
// Ports: i_clk, i_rst_n (async low), i_src raw sources, i_iobus_* request
// (re/we/sel/addr/wdata), o_iobus_rdata/o_iobus_ack reply, o_irq to MCU.
import otter_intc_pkg::*;

module otter_intc #(
    parameter int          N_SRC       = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_1000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_SRC-1:0] i_src,
    input  logic             i_iobus_re,
    input  logic             i_iobus_we,
    input  logic [3:0]       i_iobus_sel,
    input  logic [31:0]      i_iobus_addr,
    input  logic [31:0]      i_iobus_wdata,
    output logic [31:0]      o_iobus_rdata,
    output logic             o_iobus_ack,
    output logic             o_irq
);

    logic [N_SRC-1:0] w_synced;
    logic [N_SRC-1:0] r_prev;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_enable;
    logic [N_SRC-1:0] r_edge;
    intc_state_t      r_state;
    intc_state_t      w_state_nx;
    logic [ID_W-1:0]  r_isvc;
    logic [ID_W-1:0]  w_isvc_nx;

    for (genvar i = 0; i < N_SRC; i++) begin : g_sync
        logic [SYNC_STAGES-1:0] r_chain;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) r_chain <= '0;
            else          r_chain <= {r_chain[SYNC_STAGES-2:0], i_src[i]};
        end
        assign w_synced[i] = r_chain[SYNC_STAGES-1];
    end

    logic [N_SRC-1:0] w_rise;
    assign w_rise = w_synced & ~r_prev;

    // Wrapping subtraction turns addresses below the base into huge
    // offsets, so a single compare bounds both ends of the window.
    logic [31:0] w_off;
    logic        w_hit;
    logic        w_rd;
    logic        w_wr;
    logic [4:0]  w_word;
    assign w_off  = i_iobus_addr - BASE_ADDR;
    assign w_hit  = (i_iobus_re | i_iobus_we) && (w_off < WINDOW_BYTES);
    assign w_rd   = w_hit & i_iobus_re & ~i_iobus_we;
    assign w_wr   = w_hit & i_iobus_we;
    assign w_word = {w_off[4:2], 2'b00};

    logic [31:0]      w_lane;
    logic [N_SRC-1:0] w_wmask;
    assign w_lane  = {{8{i_iobus_sel[3]}}, {8{i_iobus_sel[2]}},
                      {8{i_iobus_sel[1]}}, {8{i_iobus_sel[0]}}};
    assign w_wmask = i_iobus_wdata[N_SRC-1:0] & w_lane[N_SRC-1:0];

    logic [N_SRC-1:0] w_pe;
    logic             w_pe_any;
    logic [ID_W-1:0]  w_pe_idx;
    assign w_pe = r_pending & r_enable;

    otter_intc_prio_enc #(.N(N_SRC)) u_prio (
        .i_vec   (w_pe),
        .o_valid (w_pe_any),
        .o_idx   (w_pe_idx)
    );

    logic [ID_W-1:0] w_claim_val;
    logic            w_claim;
    logic            w_complete;
    assign w_claim_val = (r_state == IDLE && w_pe_any)
                         ? w_pe_idx + ID_W'(1) : '0;
    assign w_claim     = w_rd && (w_word == OFF_CLAIM)
                         && (r_state == IDLE) && w_pe_any;
    assign w_complete  = w_wr && (w_word == OFF_CLAIM)
                         && (|i_iobus_sel) && (r_state == CLAIMED)
                         && (i_iobus_wdata[ID_W-1:0] == r_isvc);

    always_comb begin
        w_state_nx = r_state;
        w_isvc_nx  = r_isvc;
        unique case (r_state)
            IDLE: begin
                if (w_claim) begin
                    w_state_nx = CLAIMED;
                    w_isvc_nx  = w_claim_val;
                end
            end
            CLAIMED: begin
                if (w_complete) begin
                    w_state_nx = IDLE;
                    w_isvc_nx  = '0;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_isvc_nx  = '0;
            end
        endcase
    end

    // Edge bits: clears (W1C or claim) lose to a same-cycle rise.
    // Level bits simply follow the synchronised input.
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_pend_nx;
    always_comb begin
        w_clr = '0;
        if (w_wr && w_word == OFF_PENDING) w_clr = w_wmask;
        if (w_claim) w_clr = w_clr | (N_SRC'(1) << w_pe_idx);
        w_pend_nx = (r_edge & ((r_pending & ~w_clr) | w_rise))
                  | (~r_edge & w_synced);
    end

    logic [31:0] w_rval;
    always_comb begin
        w_rval = '0;
        unique case (w_word)
            OFF_PENDING:   w_rval = 32'(r_pending);
            OFF_ENABLE:    w_rval = 32'(r_enable);
            OFF_EDGE:      w_rval = 32'(r_edge);
            OFF_CLAIM:     w_rval = 32'(w_claim_val);
            OFF_INSERVICE: w_rval = 32'(r_isvc);
            default:       w_rval = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_isvc  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_isvc  <= w_isvc_nx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev        <= '0;
            r_pending     <= '0;
            r_enable      <= '0;
            r_edge        <= '0;
            o_irq         <= 1'b0;
            o_iobus_ack   <= 1'b0;
            o_iobus_rdata <= '0;
        end else begin
            r_prev    <= w_synced;
            r_pending <= w_pend_nx;
            if (w_wr && w_word == OFF_ENABLE)
                r_enable <= (r_enable & ~w_lane[N_SRC-1:0]) | w_wmask;
            if (w_wr && w_word == OFF_EDGE)
                r_edge <= (r_edge & ~w_lane[N_SRC-1:0]) | w_wmask;
            o_irq         <= (w_state_nx == IDLE) && (|w_pe);
            o_iobus_ack   <= w_hit;
            o_iobus_rdata <= w_rd ? w_rval : '0;
        end
    end

endmodule

// File: tb/tb_otter_intc.sv
// Directed bench for otter_intc against a behavioural register model.
// Ports: none; drives the DUT bus and sources, checks every cycle.
module tb_otter_intc;

    localparam int          SYNC = 2;
    localparam logic [31:0] B    = 32'h0001_1000;
    localparam logic [31:0] A_P  = B + 32'h00;
    localparam logic [31:0] A_E  = B + 32'h04;
    localparam logic [31:0] A_ED = B + 32'h08;
    localparam logic [31:0] A_C  = B + 32'h0C;
    localparam logic [31:0] A_IS = B + 32'h10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] src;
    logic        re, we;
    logic [3:0]  sel;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ack, irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    otter_intc dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_src         (src),
        .i_iobus_re    (re),
        .i_iobus_we    (we),
        .i_iobus_sel   (sel),
        .i_iobus_addr  (addr),
        .i_iobus_wdata (wdata),
        .o_iobus_rdata (rdata),
        .o_iobus_ack   (ack),
        .o_irq         (irq)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Model: sources seen SYNC samples late, registers as plain words,
    // in-service id as an integer (0 = nothing claimed).
    logic [31:0] m_hist [SYNC+1];
    logic [31:0] m_pend = '0, m_en = '0, m_edge = '0, m_rdata = '0;
    int          m_isv = 0;
    logic        m_irq = 1'b0, m_ack = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] syn, prv, offv, lane, clr, pe, rv, np;
        logic        hit;
        int          w, id, nisv;
        if (!rst_n) begin
            for (int i = 0; i <= SYNC; i++) m_hist[i] = '0;
            m_pend = '0; m_en = '0; m_edge = '0; m_isv = 0;
            m_irq = 0; m_ack = 0; m_rdata = '0;
        end else begin
            syn  = m_hist[SYNC-1];
            prv  = m_hist[SYNC];
            offv = addr - B;
            hit  = (re || we) && offv < 32'd20;
            w    = int'(offv >> 2);
            pe   = m_pend & m_en;
            id   = lowest(pe);
            case (w)
                0: rv = m_pend;
                1: rv = m_en;
                2: rv = m_edge;
                3: rv = (m_isv == 0 && id >= 0) ? 32'(id + 1) : '0;
                default: rv = 32'(m_isv);
            endcase
            lane = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            nisv = m_isv;
            clr  = '0;
            if (hit && re && !we && w == 3 && m_isv == 0 && id >= 0) begin
                nisv    = id + 1;
                clr[id] = 1'b1;
            end
            if (hit && we && w == 3 && sel != 0 && m_isv != 0
                && int'(wdata[5:0]) == m_isv) nisv = 0;
            if (hit && we && w == 0) clr = clr | (wdata & lane);
            for (int b = 0; b < 32; b++)
                np[b] = m_edge[b] ? ((m_pend[b] && !clr[b]) ||
                                     (syn[b] && !prv[b]))
                                  : syn[b];
            if (hit && we && w == 1) m_en = (m_en & ~lane) | (wdata & lane);
            if (hit && we && w == 2)
                m_edge = (m_edge & ~lane) | (wdata & lane);
            m_irq   = (nisv == 0) && (pe != 0);
            m_ack   = hit;
            m_rdata = (hit && re && !we) ? rv : '0;
            m_pend  = np;
            m_isv   = nisv;
            for (int i = SYNC; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = src;
        end
    end

    always @(negedge clk) begin
        chk("irq", 32'(irq), 32'(m_irq));
        chk("ack", 32'(ack), 32'(m_ack));
        chk("rdata", rdata, m_rdata);
    end

    task automatic rd(input logic [31:0] a, output logic [31:0] d,
                      output logic k);
        addr = a; re = 1; sel = 4'hF;
        @(negedge clk);
        d = rdata; k = ack;
        re = 0; addr = '0;
    endtask

    task automatic rdchk(input logic [31:0] a, input logic [31:0] exp,
                         input string nm);
        logic [31:0] d;
        logic        k;
        rd(a, d, k);
        chk(nm, d, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s = 4'hF);
        addr = a; wdata = d; sel = s; we = 1;
        @(negedge clk);
        we = 0; addr = '0; wdata = '0;
    endtask

    task automatic rw(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; sel = 4'hF; re = 1; we = 1;
        @(negedge clk);
        re = 0; we = 0; addr = '0; wdata = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic        k;
        rst_n = 0; src = '1; re = 0; we = 0;
        sel = '0; addr = '0; wdata = '0;
        idle(3);
        rd(A_C, d, k);
        chk("rst_rdata", d, 0);
        chk("rst_ack", 32'(k), 0);
        chk("rst_irq", 32'(irq), 0);
        rst_n = 1;
        idle(6);
        chk("en0_irq", 32'(irq), 0);
        rdchk(A_E, 0, "enable_rst");
        rdchk(A_P, 32'hFFFF_FFFF, "level_pend");
        src = '0;
        idle(4);
        rdchk(A_P, 0, "level_drop");

        wr(A_ED, 1);
        wr(A_E, 1);
        src = 32'h1;
        idle(1);
        src = '0;
        idle(2);
        chk("edge_lat_early", 32'(irq), 0);
        idle(1);
        chk("edge_lat", 32'(irq), 1);
        rdchk(A_P, 1, "edge_pend");
        rdchk(A_C, 1, "claim_edge");
        chk("claim_irq_drop", 32'(irq), 0);
        rdchk(A_P, 0, "claim_clr");
        rdchk(A_IS, 1, "isvc1");
        wr(A_C, 1);
        rdchk(A_IS, 0, "complete1");

        wr(A_ED, 0);
        wr(A_E, 32'h28);
        src = 32'h28;
        idle(5);
        chk("lvl_irq", 32'(irq), 1);
        rdchk(A_C, 4, "prio");
        rdchk(A_C, 0, "claim_busy");
        wr(A_C, 6);
        rdchk(A_IS, 4, "mismatch");
        wr(A_C, 4);
        chk("reraise", 32'(irq), 1);
        rdchk(A_C, 4, "reclaim");
        wr(A_C, 4);
        src = '0;
        wr(A_E, 0);
        idle(4);

        wr(A_ED, 4);
        src = 32'h4;
        idle(1);
        src = '0;
        idle(1);
        wr(A_P, 4);
        rdchk(A_P, 4, "set_wins");
        wr(A_P, 4);
        rdchk(A_P, 0, "w1c");

        rd(B + 32'h14, d, k);
        chk("oow_ack", 32'(k), 0);
        chk("oow_rdata", d, 0);
        wr(A_ED, 0);
        wr(A_E, 8);
        src = 32'h8;
        idle(5);
        rdchk(A_C, 4, "claim3");
        rw(A_C, 4);
        rdchk(A_IS, 0, "rw_complete");
        rw(A_C, 4);
        rdchk(A_IS, 0, "rw_noclaim");
        chk("rw_irq", 32'(irq), 1);
        src = '0;
        wr(A_E, 0);
        wr(A_E, 32'hFFFF_FFFF, 4'b0010);
        rdchk(A_E, 32'h0000_FF00, "lane");

        wr(A_E, 8);
        src = 32'h8;
        idle(5);
        chk("pre_claim_irq", 32'(irq), 1);
        rdchk(A_C, 4, "claim4");
        addr = A_IS; re = 1; sel = 4'hF;
        #2 rst_n = 0;
        #1 chk("async_irq", 32'(irq), 0);
        chk("async_ack", 32'(ack), 0);
        @(negedge clk);
        chk("inflight_ack", 32'(ack), 0);
        re = 0; addr = '0; src = '0;
        idle(1);
        rst_n = 1;
        idle(1);
        rdchk(A_IS, 0, "rst_isvc");
        rdchk(A_E, 0, "rst_en");
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
